// File: rtl/hazard_if.sv
// rtl/hazard_if.sv - decode/execute/memory hazard signals shared by the pipeline and hazard_ctrl
interface hazard_if;
  logic [4:0]  a1_d;
  logic [4:0]  a2_d;
  logic [2:0]  tuse_rs_d;
  logic [2:0]  tuse_rt_d;
  logic [4:0]  a3_e;
  logic [4:0]  a3_m;
  logic        regwrite_e;
  logic        regwrite_m;
  logic [2:0]  tnew_e;
  logic [2:0]  tnew_m;
  logic        md_use_d;
  logic        md_start_e;
  logic        md_is_div_e;
  logic        excp_m;
  logic        eret_m;
  logic        stall;
  logic        flush_e;
  logic        flush_all;
  logic        md_busy;
  logic [31:0] stall_cycles;

  modport master (
    output a1_d, a2_d, tuse_rs_d, tuse_rt_d, a3_e, a3_m, regwrite_e, regwrite_m,
           tnew_e, tnew_m, md_use_d, md_start_e, md_is_div_e, excp_m, eret_m,
    input  stall, flush_e, flush_all, md_busy, stall_cycles
  );

  modport slave (
    input  a1_d, a2_d, tuse_rs_d, tuse_rt_d, a3_e, a3_m, regwrite_e, regwrite_m,
           tnew_e, tnew_m, md_use_d, md_start_e, md_is_div_e, excp_m, eret_m,
    output stall, flush_e, flush_all, md_busy, stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - decode/execute hazard sequencer: Tuse/Tnew stalls, HI/LO busy FSM, flushes, stall counter
module hazard_ctrl #(
  parameter int          MULT_CYCLES    = 5,
  parameter int          DIV_CYCLES     = 10,
  parameter logic [2:0]  TUSE_NONE      = 3'd7,
  parameter logic [31:0] STALL_CNT_INIT = 32'd0
) (
  input  logic   clk,
  input  logic   reset,
  hazard_if.slave hz
);

  typedef enum logic [1:0] {IDLE, MUL_BUSY, DIV_BUSY} state_t;

  localparam logic [3:0] MUL_LOAD = 4'(MULT_CYCLES - 2);
  localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 2);

  state_t      state;
  logic [3:0]  md_cnt;
  logic [31:0] stall_cnt;
  logic        hz_rs, hz_rt, flush_all, md_busy, stall;

  assign hz_rs = (hz.tuse_rs_d != TUSE_NONE) && (hz.a1_d != 5'd0) &&
                 ((hz.regwrite_e && hz.a3_e == hz.a1_d && hz.tnew_e > hz.tuse_rs_d) ||
                  (hz.regwrite_m && hz.a3_m == hz.a1_d && hz.tnew_m > hz.tuse_rs_d));

  assign hz_rt = (hz.tuse_rt_d != TUSE_NONE) && (hz.a2_d != 5'd0) &&
                 ((hz.regwrite_e && hz.a3_e == hz.a2_d && hz.tnew_e > hz.tuse_rt_d) ||
                  (hz.regwrite_m && hz.a3_m == hz.a2_d && hz.tnew_m > hz.tuse_rt_d));

  // Everything is quiet during reset except flush_e, which keeps a bubble in ID/EX.
  assign flush_all = !reset && (hz.excp_m || hz.eret_m);
  assign md_busy   = !reset && ((state != IDLE) || (hz.md_start_e && !flush_all));
  assign stall     = !reset && !flush_all && (hz_rs || hz_rt || (hz.md_use_d && md_busy));

  assign hz.flush_all    = flush_all;
  assign hz.md_busy      = md_busy;
  assign hz.stall        = stall;
  assign hz.flush_e      = reset || stall || flush_all;
  assign hz.stall_cycles = stall_cnt;

  // A start squashed by a same-cycle flush never enters BUSY; a running op is never aborted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      md_cnt <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (hz.md_start_e && !flush_all) begin
            state  <= hz.md_is_div_e ? DIV_BUSY : MUL_BUSY;
            md_cnt <= hz.md_is_div_e ? DIV_LOAD : MUL_LOAD;
          end
        end
        MUL_BUSY, DIV_BUSY: begin
          if (md_cnt == 4'd0) state <= IDLE;
          else                md_cnt <= md_cnt - 4'd1;
        end
        default: begin
          state  <= IDLE;
          md_cnt <= 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                                   stall_cnt <= STALL_CNT_INIT;
    else if (stall && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hazard_if bus();
  hazard_if bus2();

  hazard_ctrl u_dut (.clk(clk), .reset(reset), .hz(bus.slave));
  hazard_ctrl #(.STALL_CNT_INIT(32'hFFFF_FFFD)) u_sat (.clk(clk), .reset(reset), .hz(bus2.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.a1_d = 5'd0;        bus.a2_d = 5'd0;
    bus.tuse_rs_d = 3'd7;   bus.tuse_rt_d = 3'd7;
    bus.a3_e = 5'd0;        bus.a3_m = 5'd0;
    bus.regwrite_e = 1'b0;  bus.regwrite_m = 1'b0;
    bus.tnew_e = 3'd0;      bus.tnew_m = 3'd0;
    bus.md_use_d = 1'b0;    bus.md_start_e = 1'b0;  bus.md_is_div_e = 1'b0;
    bus.excp_m = 1'b0;      bus.eret_m = 1'b0;
  endtask

  initial begin
    logic [63:0] sat_exp;
    reset = 1'b1;
    idle_bus();
    bus2.a1_d = 5'd0;       bus2.a2_d = 5'd0;
    bus2.tuse_rs_d = 3'd7;  bus2.tuse_rt_d = 3'd7;
    bus2.a3_e = 5'd0;       bus2.a3_m = 5'd0;
    bus2.regwrite_e = 1'b0; bus2.regwrite_m = 1'b0;
    bus2.tnew_e = 3'd0;     bus2.tnew_m = 3'd0;
    bus2.md_use_d = 1'b0;   bus2.md_start_e = 1'b0; bus2.md_is_div_e = 1'b0;
    bus2.excp_m = 1'b0;     bus2.eret_m = 1'b0;
    tick();
    tick();

    // reset state, with a hazard present to prove outputs are gated
    bus.regwrite_e = 1'b1; bus.a3_e = 5'd8; bus.tnew_e = 3'd2; bus.a1_d = 5'd8; bus.tuse_rs_d = 3'd1;
    #1;
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_flush_e", 32'(bus.flush_e), 32'd1);
    check("rst_flush_all", 32'(bus.flush_all), 32'd0);
    check("rst_md_busy", 32'(bus.md_busy), 32'd0);
    check("rst_cnt", bus.stall_cycles, 32'd0);
    check("rst_cnt_sat", bus2.stall_cycles, 32'hFFFF_FFFD);
    reset = 1'b0;
    #1;

    // load-use through EX
    check("lu_stall", 32'(bus.stall), 32'd1);
    check("lu_flush_e", 32'(bus.flush_e), 32'd1);
    tick();
    bus.tnew_e = 3'd1;
    #1;
    check("lu_next_stall", 32'(bus.stall), 32'd0);
    check("lu_next_flush_e", 32'(bus.flush_e), 32'd0);
    check("lu_cnt", bus.stall_cycles, 32'd1);

    // rt hazard through MEM, then equal tnew/tuse is no hazard
    idle_bus();
    bus.regwrite_m = 1'b1; bus.a3_m = 5'd5; bus.tnew_m = 3'd1; bus.a2_d = 5'd5; bus.tuse_rt_d = 3'd0;
    #1;
    check("rt_m_stall", 32'(bus.stall), 32'd1);
    tick();
    bus.tuse_rt_d = 3'd1;
    #1;
    check("rt_m_equal", 32'(bus.stall), 32'd0);
    check("rt_cnt", bus.stall_cycles, 32'd2);

    // $0 and unused-operand cases
    idle_bus();
    bus.regwrite_e = 1'b1; bus.a3_e = 5'd0; bus.a1_d = 5'd0; bus.tnew_e = 3'd2; bus.tuse_rs_d = 3'd0;
    #1;
    check("zero_reg", 32'(bus.stall), 32'd0);
    bus.a3_e = 5'd9; bus.a2_d = 5'd9; bus.tuse_rt_d = 3'd7;
    #1;
    check("tuse_none", 32'(bus.stall), 32'd0);
    bus.tuse_rt_d = 3'd0;
    #1;
    check("tuse_rt0", 32'(bus.stall), 32'd1);
    idle_bus();
    #1;

    // mult with mflo in decode: 5 stall cycles
    bus.md_start_e = 1'b1; bus.md_is_div_e = 1'b0; bus.md_use_d = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("mul_stall_%0d", i), 32'(bus.stall), 32'd1);
      check($sformatf("mul_busy_%0d", i), 32'(bus.md_busy), 32'd1);
      tick();
      bus.md_start_e = 1'b0;
    end
    #1;
    check("mul_done_stall", 32'(bus.stall), 32'd0);
    check("mul_done_busy", 32'(bus.md_busy), 32'd0);
    check("mul_cnt", bus.stall_cycles, 32'd7);

    // div: 10 stall cycles
    bus.md_start_e = 1'b1; bus.md_is_div_e = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check($sformatf("div_stall_%0d", i), 32'(bus.stall), 32'd1);
      tick();
      bus.md_start_e = 1'b0;
    end
    #1;
    check("div_done_stall", 32'(bus.stall), 32'd0);
    check("div_cnt", bus.stall_cycles, 32'd17);
    idle_bus();

    // exception with a start and a load-use hazard
    bus.excp_m = 1'b1; bus.md_start_e = 1'b1;
    bus.regwrite_e = 1'b1; bus.a3_e = 5'd8; bus.tnew_e = 3'd2; bus.a1_d = 5'd8; bus.tuse_rs_d = 3'd1;
    #1;
    check("ex_flush_all", 32'(bus.flush_all), 32'd1);
    check("ex_flush_e", 32'(bus.flush_e), 32'd1);
    check("ex_stall", 32'(bus.stall), 32'd0);
    check("ex_busy", 32'(bus.md_busy), 32'd0);
    tick();
    idle_bus();
    #1;
    check("ex_next_busy", 32'(bus.md_busy), 32'd0);
    check("ex_cnt", bus.stall_cycles, 32'd17);
    bus.eret_m = 1'b1;
    #1;
    check("eret_flush_all", 32'(bus.flush_all), 32'd1);
    idle_bus();

    // running mult survives a later exception
    bus.md_start_e = 1'b1;
    tick();
    bus.md_start_e = 1'b0; bus.excp_m = 1'b1;
    #1;
    check("busy_excp_busy", 32'(bus.md_busy), 32'd1);
    tick();
    bus.excp_m = 1'b0;
    tick();
    tick();
    #1;
    check("busy_excp_last", 32'(bus.md_busy), 32'd1);
    tick();
    check("busy_excp_idle", 32'(bus.md_busy), 32'd0);

    // reset at cycle 3 of a div
    bus.md_start_e = 1'b1; bus.md_is_div_e = 1'b1; bus.md_use_d = 1'b1;
    tick();
    bus.md_start_e = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("rdiv_busy_in_rst", 32'(bus.md_busy), 32'd0);
    check("rdiv_flush_e_in_rst", 32'(bus.flush_e), 32'd1);
    tick();
    reset = 1'b0;
    #1;
    check("rdiv_busy", 32'(bus.md_busy), 32'd0);
    check("rdiv_stall", 32'(bus.stall), 32'd0);
    check("rdiv_cnt", bus.stall_cycles, 32'd0);
    idle_bus();

    // saturation on the preloaded instance
    bus2.regwrite_e = 1'b1; bus2.a3_e = 5'd8; bus2.tnew_e = 3'd2; bus2.a1_d = 5'd8; bus2.tuse_rs_d = 3'd1;
    for (int k = 1; k <= 5; k++) begin
      #1;
      check($sformatf("sat_stall_%0d", k), 32'(bus2.stall), 32'd1);
      tick();
      sat_exp = 64'hFFFF_FFFD + 64'(k);
      if (sat_exp > 64'hFFFF_FFFF) sat_exp = 64'hFFFF_FFFF;
      check($sformatf("sat_cnt_%0d", k), bus2.stall_cycles, sat_exp[31:0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
